// File: rtl/regfile32_pkg.sv
// Shared widths and FSM encoding for the 32-entry register bank write side.
package regfile32_pkg;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  localparam int LEN_W  = 5;

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;
endpackage

// File: rtl/decoder_5_to_32.sv
// Index-to-one-hot decoder producing the per-entry write enables.
module decoder_5_to_32
  import regfile32_pkg::*;
(
  input  logic [ADDR_W-1:0] idx,
  input  logic              en,
  output logic [DEPTH-1:0]  onehot
);

  always_comb begin
    onehot      = '0;
    onehot[idx] = en;
  end

endmodule

// File: rtl/regfile32_writer.sv
// Burst write side of the 32-entry register bank: command channel, data channel,
// auto-incrementing address, all entries exported on q.
//
//   state   | meaning
//   S_IDLE  | waiting for a command (cmd_ready high once out of reset)
//   S_BURST | accepting data beats until remaining reaches zero
module regfile32_writer
  import regfile32_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic [N-1:0]         data,
  output logic [DEPTH*N-1:0]   q,
  output logic                 busy,
  output logic                 done
);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic [DEPTH-1:0]  we;
  logic              beat;

  assign beat = data_valid & data_ready;

  // Handshake outputs are registers so nothing reaches them combinationally
  // from the inputs, and cmd_ready stays low through reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      addr       <= '0;
      remaining  <= '0;
      cmd_ready  <= 1'b0;
      data_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            addr       <= cmd_addr;
            remaining  <= cmd_len;
            state      <= S_BURST;
            cmd_ready  <= 1'b0;
            data_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_BURST: begin
          if (beat) begin
            addr <= addr + 1'b1;
            if (remaining == '0) begin
              state      <= S_IDLE;
              cmd_ready  <= 1'b1;
              data_ready <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else begin
              remaining <= remaining - 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  decoder_5_to_32 u_dec (
    .idx    (addr),
    .en     (beat),
    .onehot (we)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [N-1:0] r;
    always_ff @(posedge clk) begin
      if (rst)        r <= '0;
      else if (we[i]) r <= data;
    end
    assign q[i*N +: N] = r;
  end

endmodule

// File: tb/tb_regfile32_writer.sv
// Directed bench for regfile32_writer with hand-computed expectations.
module tb_regfile32_writer;
  localparam int N = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [4:0]      cmd_addr;
  logic [4:0]      cmd_len;
  logic            data_valid;
  logic            data_ready;
  logic [N-1:0]    data;
  logic [32*N-1:0] q;
  logic            busy;
  logic            done;

  int checks   = 0;
  int failures = 0;

  regfile32_writer #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data       (data),
    .q          (q),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] entry(input int i);
    return q[i*N +: N];
  endfunction

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [4:0] a, input logic [4:0] l);
    int n;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_ready) chk("cmd_timeout", 32'd0, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [N-1:0] d);
    int n;
    data_valid = 1'b1;
    data       = d;
    n = 0;
    while (!data_ready && n < 50) begin
      tick();
      n++;
    end
    if (!data_ready) chk("beat_timeout", 32'd0, 32'd1);
    tick();
    data_valid = 1'b0;
  endtask

  initial begin
    int nz;
    int dones;
    logic [N-1:0] exp_q [32];
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_addr   = '0;
    cmd_len    = '0;
    data_valid = 1'b0;
    data       = '0;

    // Power-on reset
    repeat (3) tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_data_ready", 32'(data_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    nz = 0;
    for (int i = 0; i < 32; i++) if (entry(i) !== '0) nz++;
    chk("rst_q_zero", 32'(nz), 32'd0);
    rst = 1'b0;
    tick();
    chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

    // Single beat
    send_cmd(5'd5, 5'd0);
    chk("single_data_ready", 32'(data_ready), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_cmd_ready_low", 32'(cmd_ready), 32'd0);
    send_beat(32'hDEADBEEF);
    chk("single_q5", entry(5), 32'hDEADBEEF);
    chk("single_done", 32'(done), 32'd1);
    chk("single_busy_low", 32'(busy), 32'd0);
    chk("single_cmd_ready", 32'(cmd_ready), 32'd1);
    nz = 0;
    for (int i = 0; i < 32; i++) if (i != 5 && entry(i) !== '0) nz++;
    chk("single_others_zero", 32'(nz), 32'd0);
    tick();
    chk("single_done_one_cycle", 32'(done), 32'd0);

    // Wrap across entry 31
    send_cmd(5'd30, 5'd3);
    send_beat(32'hA);
    send_beat(32'hB);
    send_beat(32'hC);
    send_beat(32'hD);
    chk("wrap_q30", entry(30), 32'hA);
    chk("wrap_q31", entry(31), 32'hB);
    chk("wrap_q0", entry(0), 32'hC);
    chk("wrap_q1", entry(1), 32'hD);
    chk("wrap_q5_hold", entry(5), 32'hDEADBEEF);
    chk("wrap_done", 32'(done), 32'd1);
    tick();

    // Stalls: data_valid 1,0,0,1,0,1 writes beats from cycles 0, 3 and 5
    send_cmd(5'd0, 5'd2);
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      data_valid = (k == 0 || k == 3 || k == 5);
      data       = 32'h100 + 32'(k);
      tick();
      if (k < 5 && done) dones++;
    end
    data_valid = 1'b0;
    chk("stall_no_early_done", 32'(dones), 32'd0);
    chk("stall_done", 32'(done), 32'd1);
    chk("stall_q0", entry(0), 32'h100);
    chk("stall_q1", entry(1), 32'h103);
    chk("stall_q2", entry(2), 32'h105);
    chk("stall_q3_untouched", entry(3), 32'h0);
    chk("stall_q30_hold", entry(30), 32'hA);
    tick();

    // Back-to-back: cmd_valid held, second command taken in the done cycle
    send_cmd(5'd20, 5'd1);
    cmd_valid = 1'b1;
    cmd_addr  = 5'd10;
    cmd_len   = 5'd0;
    send_beat(32'h55);
    chk("b2b_mid_busy", 32'(busy), 32'd1);
    send_beat(32'h66);
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("b2b_second_accepted", 32'(data_ready), 32'd1);
    chk("b2b_second_busy", 32'(busy), 32'd1);
    chk("b2b_done_low", 32'(done), 32'd0);
    send_beat(32'h77);
    chk("b2b_q10", entry(10), 32'h77);
    chk("b2b_q20", entry(20), 32'h55);
    chk("b2b_q21", entry(21), 32'h66);
    chk("b2b_done2", 32'(done), 32'd1);
    tick();

    // Full 32-beat sweep from entry 7
    send_cmd(5'd7, 5'd31);
    for (int i = 0; i < 32; i++) begin
      if (i == 31) chk("sweep_busy_before_last", 32'(busy), 32'd1);
      send_beat(32'(i));
    end
    chk("sweep_busy_low", 32'(busy), 32'd0);
    chk("sweep_done", 32'(done), 32'd1);
    chk("sweep_q6_last", entry(6), 32'd31);
    chk("sweep_q7_first", entry(7), 32'd0);
    for (int i = 0; i < 32; i++) exp_q[(7 + i) % 32] = 32'(i);
    nz = 0;
    for (int i = 0; i < 32; i++) if (entry(i) !== exp_q[i]) nz++;
    chk("sweep_all_entries", 32'(nz), 32'd0);
    tick();

    // Reset mid-burst after 2 beats
    send_cmd(5'd0, 5'd5);
    send_beat(32'hAA);
    send_beat(32'hBB);
    chk("mid_q0", entry(0), 32'hAA);
    chk("mid_q1", entry(1), 32'hBB);
    rst = 1'b1;
    dones = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done) dones++;
    end
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_data_ready", 32'(data_ready), 32'd0);
    chk("mid_rst_no_done", 32'(dones), 32'd0);
    nz = 0;
    for (int i = 0; i < 32; i++) if (entry(i) !== '0) nz++;
    chk("mid_rst_q_zero", 32'(nz), 32'd0);
    rst = 1'b0;
    tick();
    chk("mid_cmd_ready_after", 32'(cmd_ready), 32'd1);
    chk("mid_done_after", 32'(done), 32'd0);
    chk("mid_busy_after", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
